game_controller: RTL and testbench

Sequencing controller for the 2048 move/merge datapath. It owns the board and score registers and accepts one-hot direction requests from the button front end. For each request it runs one cycle of the combinational move/merge block, commits the result, spawns a new tile from an LFSR, then evaluates win/lose. It sits between the input debouncers and the VGA/board renderer, which read its `board`, `score` and status outputs.

---
 rtl/game_controller.sv | 168 ++++++++++++++++
 tb/tb_game_controller.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_controller.sv
// rtl/game_controller.sv - 2048 sequencer: board/score registers, LFSR tile spawn, win/lose evaluation
module game_controller #(
    parameter logic [11:0] WIN_VALUE = 12'd2048,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            btn_dir,
    input  logic                  load_en,
    input  logic [3:0][3:0][11:0] load_board,
    output logic [3:0]            mm_direction,
    output logic [3:0][3:0][11:0] mm_board_in,
    input  logic [3:0][3:0][11:0] mm_board_out,
    input  logic [19:0]           mm_score,
    output logic [3:0][3:0][11:0] board,
    output logic [19:0]           score,
    output logic                  busy,
    output logic                  game_won,
    output logic                  game_over
);
    typedef logic [3:0][3:0][11:0] board_t;
    typedef enum logic [2:0] {INIT1, INIT2, IDLE, MOVE, SPAWN, CHECK, WON, OVER} state_t;

    state_t      state_q, state_d;
    board_t      board_q, board_d;
    logic [19:0] score_q, score_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [3:0]  dir_q, dir_d;
    logic [3:0]  btn_prev_q, btn_prev_d;
    logic        won_q, won_d;
    logic        over_q, over_d;

    logic        has_win, has_zero, has_pair, one_hot;
    logic [20:0] score_sum;
    board_t      spawned;

    // First empty cell at or after lfsr[3:0] (wrapping) gets a 2, or a 4 when lfsr[7:4] is zero.
    function automatic board_t spawn_tile(input board_t b, input logic [15:0] r);
        board_t     res;
        logic       found;
        logic [3:0] idx;
        res   = b;
        found = 1'b0;
        for (int k = 0; k < 16; k++) begin
            idx = r[3:0] + 4'(k);
            if (!found && b[idx[3:2]][idx[1:0]] == 12'd0) begin
                res[idx[3:2]][idx[1:0]] = (r[7:4] == 4'd0) ? 12'd4 : 12'd2;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    always_comb begin
        has_win  = 1'b0;
        has_zero = 1'b0;
        has_pair = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (board_q[r][c] == WIN_VALUE) has_win = 1'b1;
                if (board_q[r][c] == 12'd0)     has_zero = 1'b1;
            end
            for (int c = 0; c < 3; c++) begin
                if (board_q[r][c] == board_q[r][c+1]) has_pair = 1'b1;
            end
        end
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (board_q[r][c] == board_q[r+1][c]) has_pair = 1'b1;
            end
        end
    end

    assign one_hot   = (btn_dir != 4'd0) && ((btn_dir & (btn_dir - 4'd1)) == 4'd0);
    assign score_sum = {1'b0, score_q} + {1'b0, mm_score};
    assign spawned   = spawn_tile(board_q, lfsr_q);

    always_comb begin
        state_d    = state_q;
        board_d    = board_q;
        score_d    = score_q;
        dir_d      = dir_q;
        won_d      = won_q;
        over_d     = over_q;
        btn_prev_d = btn_dir;
        lfsr_d     = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        if (load_en) begin
            board_d = load_board;
            score_d = '0;
            won_d   = 1'b0;
            over_d  = 1'b0;
            state_d = CHECK;
        end else begin
            case (state_q)
                INIT1: begin
                    board_d = spawned;
                    state_d = INIT2;
                end
                INIT2: begin
                    board_d = spawned;
                    state_d = IDLE;
                end
                IDLE: begin
                    if (one_hot && btn_prev_q == 4'd0) begin
                        dir_d   = btn_dir;
                        state_d = MOVE;
                    end
                end
                MOVE: begin
                    if (mm_board_out != board_q) begin
                        board_d = mm_board_out;
                        score_d = score_sum[20] ? 20'hFFFFF : score_sum[19:0];
                        state_d = SPAWN;
                    end else begin
                        state_d = IDLE;
                    end
                end
                SPAWN: begin
                    board_d = spawned;
                    state_d = CHECK;
                end
                CHECK: begin
                    if (has_win) begin
                        won_d   = 1'b1;
                        state_d = WON;
                    end else if (!has_zero && !has_pair) begin
                        over_d  = 1'b1;
                        state_d = OVER;
                    end else begin
                        state_d = IDLE;
                    end
                end
                WON, OVER: state_d = state_q;
                default:   state_d = INIT1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= INIT1;
            board_q    <= '0;
            score_q    <= '0;
            lfsr_q     <= SEED;
            dir_q      <= '0;
            btn_prev_q <= '0;
            won_q      <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            board_q    <= board_d;
            score_q    <= score_d;
            lfsr_q     <= lfsr_d;
            dir_q      <= dir_d;
            btn_prev_q <= btn_prev_d;
            won_q      <= won_d;
            over_q     <= over_d;
        end
    end

    assign mm_direction = (state_q == MOVE) ? dir_q : 4'd0;
    assign mm_board_in  = board_q;
    assign board        = board_q;
    assign score        = score_q;
    assign busy         = (state_q != IDLE);
    assign game_won     = won_q;
    assign game_over    = over_q;
endmodule

// File: tb/tb_game_controller.sv
// tb/tb_game_controller.sv - scoreboard bench for game_controller with a behavioural 2048 move/spawn model
module tb_game_controller;
    typedef logic [3:0][3:0][11:0] board_t;
    typedef struct {
        board_t      b;
        logic [19:0] s;
        bit          w;
        bit          o;
        int          busy;
    } exp_t;

    localparam logic [11:0] WIN  = 12'd2048;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  btn_dir = 4'd0;
    logic        load_en = 1'b0;
    board_t      load_board = '0;
    logic [3:0]  mm_direction;
    board_t      mm_board_in, mm_board_out, board, mm_mv;
    logic [19:0] mm_score, mm_sc, score;
    logic        busy, game_won, game_over;
    logic        force_en = 1'b0;
    logic [19:0] force_val = '0;
    logic [15:0] m_lfsr;

    int          n_pass = 0;
    int          n_total = 0;
    exp_t        q[$];
    board_t      board_m;
    logic [19:0] score_m;
    bit          term;

    game_controller #(.WIN_VALUE(WIN), .SEED(SEED)) dut (
        .clk(clk), .rst(rst), .btn_dir(btn_dir), .load_en(load_en), .load_board(load_board),
        .mm_direction(mm_direction), .mm_board_in(mm_board_in), .mm_board_out(mm_board_out),
        .mm_score(mm_score), .board(board), .score(score), .busy(busy),
        .game_won(game_won), .game_over(game_over)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_nx(input logic [15:0] l);
        logic [15:0] bitv;
        bitv = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 16'd1;
        return (l >> 1) | (bitv << 15);
    endfunction

    function automatic board_t spawn_m(input board_t b, input logic [15:0] l);
        board_t o;
        int idx;
        o = b;
        for (int k = 0; k < 16; k++) begin
            idx = (int'(l[3:0]) + k) % 16;
            if (o[idx / 4][idx % 4] == 12'd0) begin
                o[idx / 4][idx % 4] = (l[7:4] == 4'd0) ? 12'd4 : 12'd2;
                return o;
            end
        end
        return o;
    endfunction

    function automatic bit has_win(input board_t b);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (b[r][c] == WIN) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit has_moves(input board_t b);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                if (b[r][c] == 12'd0) return 1'b1;
                if (c < 3 && b[r][c] == b[r][c+1]) return 1'b1;
                if (r < 3 && b[r][c] == b[r+1][c]) return 1'b1;
            end
        return 1'b0;
    endfunction

    // Each line is read starting from the edge tiles slide toward, compacted, and merged once per tile.
    function automatic logic [19:0] move_core(input board_t b, input logic [3:0] d, output board_t o);
        logic [19:0] sc;
        logic [11:0] v [4];
        logic [11:0] w [4];
        int r [4];
        int c [4];
        int n;
        bit can;
        sc = '0;
        o  = b;
        if (d != 4'b0001 && d != 4'b0010 && d != 4'b0100 && d != 4'b1000) return sc;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) begin
                case (d)
                    4'b0001: begin r[k] = k;     c[k] = i;     end
                    4'b0010: begin r[k] = 3 - k; c[k] = i;     end
                    4'b0100: begin r[k] = i;     c[k] = k;     end
                    default: begin r[k] = i;     c[k] = 3 - k; end
                endcase
                v[k] = b[r[k]][c[k]];
                w[k] = '0;
            end
            n   = 0;
            can = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (v[k] != 12'd0) begin
                    if (can && w[n-1] == v[k]) begin
                        w[n-1] = v[k] << 1;
                        sc     = sc + 20'(w[n-1]);
                        can    = 1'b0;
                    end else begin
                        w[n] = v[k];
                        n    = n + 1;
                        can  = 1'b1;
                    end
                end
            end
            for (int k = 0; k < 4; k++) o[r[k]][c[k]] = w[k];
        end
        return sc;
    endfunction

    always_comb begin
        mm_mv = '0;
        mm_sc = move_core(mm_board_in, mm_direction, mm_mv);
        mm_board_out = mm_mv;
        mm_score = force_en ? force_val : mm_sc;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= SEED;
        else     m_lfsr <= lfsr_nx(m_lfsr);
    end

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push(input board_t b, input logic [19:0] s, input bit w, input bit o, input int bl);
        exp_t e;
        e.b = b; e.s = s; e.w = w; e.o = o; e.busy = bl;
        q.push_back(e);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (!busy) return;
        end
        n_total++;
        $display("FAIL idle_timeout: busy still 1 after 50 cycles, expected 0");
    endtask

    task automatic expect_move(input logic [3:0] d, input logic [15:0] l);
        board_t      mv;
        logic [19:0] sc;
        int          s;
        sc = move_core(board_m, d, mv);
        if (force_en) sc = force_val;
        if (mv == board_m) begin
            push(board_m, score_m, 1'b0, 1'b0, 1);
        end else begin
            s = int'(score_m) + int'(sc);
            if (s > 'hFFFFF) s = 'hFFFFF;
            board_m = spawn_m(mv, lfsr_nx(lfsr_nx(l)));
            score_m = 20'(s);
            term    = has_win(board_m) || !has_moves(board_m);
            push(board_m, score_m, has_win(board_m), !has_win(board_m) && !has_moves(board_m), 3);
        end
    endtask

    task automatic press(input logic [3:0] d);
        if (term) begin
            @(posedge clk); #1 btn_dir = d;
            @(posedge clk); #1 btn_dir = 4'd0;
            repeat (4) @(posedge clk);
            #1;
            chk("terminal_board", board, board_m);
            chk("terminal_score", 192'(score), 192'(score_m));
            return;
        end
        wait_idle();
        btn_dir = d;
        expect_move(d, m_lfsr);
        @(posedge clk); #1 btn_dir = 4'd0;
    endtask

    task automatic load(input board_t b);
        if (!term) wait_idle();
        @(posedge clk); #1;
        load_board = b;
        load_en    = 1'b1;
        @(posedge clk); #1 load_en = 1'b0;
        board_m = b;
        score_m = '0;
        term    = has_win(b) || !has_moves(b);
        push(b, '0, has_win(b), !has_win(b) && !has_moves(b), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        board_m = spawn_m(spawn_m('0, SEED), lfsr_nx(SEED));
        score_m = '0;
        term    = 1'b0;
        push(board_m, '0, 1'b0, 1'b0, 2);
    endtask

    function automatic board_t row0(input int a, input int b, input int c, input int d);
        board_t o;
        o = '0;
        o[0][0] = 12'(a); o[0][1] = 12'(b); o[0][2] = 12'(c); o[0][3] = 12'(d);
        return o;
    endfunction

    function automatic board_t rand_board();
        board_t o;
        bit full;
        full = ($urandom_range(0, 3) == 0);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (full) o[r][c] = 12'd2 << $urandom_range(0, 1);
                else if ($urandom_range(0, 2) == 0) o[r][c] = '0;
                else o[r][c] = 12'd2 << $urandom_range(0, 4);
        return o;
    endfunction

    initial begin : monitor
        int   cnt;
        int   bl;
        bit   pb, pw, po;
        exp_t e;
        cnt = 0; pb = 1'b0; pw = 1'b0; po = 1'b0;
        forever begin
            @(negedge clk);
            if (busy) cnt++;
            if ((pb && !busy) || (game_won && !pw) || (game_over && !po)) begin
                bl = busy ? cnt - 1 : cnt;
                if (q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_event: got completion after %0d busy cycles, expected none", bl);
                end else begin
                    e = q.pop_front();
                    chk("board", board, e.b);
                    chk("score", 192'(score), 192'(e.s));
                    chk("game_won", 192'(game_won), 192'(e.w));
                    chk("game_over", 192'(game_over), 192'(e.o));
                    chk("busy_len", 192'(bl), 192'(e.busy));
                end
            end
            if (!busy || load_en || rst) cnt = 0;
            pb = busy; pw = game_won; po = game_over;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation still running at 2ms, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        board_t chkb;
        do_reset();

        load(row0(2, 2, 4, 0));
        press(4'b0100);
        load(row0(2, 0, 0, 0));
        press(4'b0100);

        load(row0(1024, 1024, 0, 0));
        press(4'b1000);
        press(4'b0100);

        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                chkb[r][c] = ((r + c) % 2 == 1) ? 12'd4 : 12'd2;
        load(chkb);
        press(4'b0100);

        load(row0(0, 2, 0, 2));
        wait_idle();
        btn_dir = 4'b0100;
        expect_move(4'b0100, m_lfsr);
        repeat (10) @(posedge clk);
        #1 btn_dir = 4'd0;
        wait_idle();
        btn_dir = 4'b0101;
        repeat (3) @(posedge clk);
        #1 btn_dir = 4'd0;
        repeat (4) @(posedge clk);
        #1;
        chk("non_onehot_board", board, board_m);
        press(4'b0001);

        load(row0(2, 2, 0, 0));
        force_en  = 1'b1;
        force_val = 20'hFFFF0;
        press(4'b0100);
        wait_idle();
        force_val = 20'd32;
        press(4'b1000);
        wait_idle();
        force_en = 1'b0;

        load(row0(0, 0, 2, 2));
        wait_idle();
        btn_dir = 4'b0100;
        @(posedge clk); #1 btn_dir = 4'd0;
        @(posedge clk); #2 rst = 1'b1;
        #1;
        chk("rst_board", board, '0);
        chk("rst_score", 192'(score), '0);
        chk("rst_flags", 192'({game_won, game_over}), '0);
        chk("rst_busy", 192'(busy), 192'(1));
        do_reset();

        for (int i = 0; i < 60; i++) begin
            if (term) load(rand_board());
            else press(4'(1 << $urandom_range(0, 3)));
        end
        if (!term) wait_idle();
        repeat (6) @(posedge clk);
        #1;
        chk("pending_events", 192'(q.size()), '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
